// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexes DIGITS 3-bit codes onto one shared seven_seg
// decoder. Each digit slot is BLANK_CYC blanked cycles followed by SHOW_CYC
// driven cycles. New display data is held pending and only committed to the
// shadow buffer at a frame boundary (or while idle), so a frame never tears.
// Every output is a flop fed from next-state logic, so outputs line up with
// the state they describe and no input reaches an output combinationally.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SHOW_CYC  = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [3*DIGITS-1:0]   data_in,
  output logic [2:0]            dec_in,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done,
  output logic                  load_ack
);

  localparam int CNT_MAX = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO   = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Pick the 3-bit code of digit i out of a packed digit vector.
  function automatic logic [2:0] digit_code(input logic [3*DIGITS-1:0] vec,
                                            input logic [IDX_W-1:0]    i);
    digit_code = vec[3*int'(i) +: 3];
  endfunction

  // One-hot select for digit i.
  function automatic logic [DIGITS-1:0] digit_sel(input logic [IDX_W-1:0] i);
    logic [DIGITS-1:0] sel;
    sel    = {DIGITS{1'b0}};
    sel[i] = 1'b1;
    digit_sel = sel;
  endfunction

  state_t              state_r,      state_nxt_s;
  logic [IDX_W-1:0]    idx_r,        idx_nxt_s;
  logic [CNT_W-1:0]    cnt_r,        cnt_nxt_s;
  logic                frame_end_s;

  logic [3*DIGITS-1:0] shadow_r,     shadow_nxt_s;
  logic [3*DIGITS-1:0] pend_r,       pend_nxt_s;
  logic                pend_flag_r,  pend_flag_nxt_s;
  logic                commit_s;

  logic [2:0]          dec_nxt_s;
  logic [DIGITS-1:0]   digit_en_nxt_s;

  // Scan state register: state, digit index and slot cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= IDX_ZERO;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Scan sequencing: dropping en aborts to IDLE from anywhere; otherwise
  // walk BLANK -> SHOW per digit and flag the wrap after the last digit.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    frame_end_s = 1'b0;
    if (!en) begin
      state_nxt_s = IDLE;
      idx_nxt_s   = IDX_ZERO;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = BLANK;
          idx_nxt_s   = IDX_ZERO;
          cnt_nxt_s   = CNT_ZERO;
        end
        BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            state_nxt_s = SHOW;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        SHOW: begin
          if (cnt_r == SHOW_LAST) begin
            state_nxt_s = BLANK;
            cnt_nxt_s   = CNT_ZERO;
            if (idx_r == IDX_LAST) begin
              idx_nxt_s   = IDX_ZERO;
              frame_end_s = 1'b1;
            end else begin
              idx_nxt_s   = idx_r + IDX_ONE;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          idx_nxt_s   = IDX_ZERO;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Data handoff: loads land in the pending buffer; commit happens only on
  // the frame-wrap edge or while idle. A load on the commit edge is newer
  // than anything pending, so it goes straight to the shadow buffer.
  always_comb begin
    commit_s        = (frame_end_s && (pend_flag_r || load)) ||
                      ((state_r == IDLE) && pend_flag_r);
    shadow_nxt_s    = shadow_r;
    pend_nxt_s      = pend_r;
    pend_flag_nxt_s = pend_flag_r;
    if (commit_s) begin
      shadow_nxt_s    = load ? data_in : pend_r;
      pend_flag_nxt_s = 1'b0;
    end else if (load) begin
      pend_nxt_s      = data_in;
      pend_flag_nxt_s = 1'b1;
    end else begin
      pend_flag_nxt_s = pend_flag_r;
    end
  end

  // Display buffers: shadow drives the digits, pending holds the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r    <= {(3*DIGITS){1'b0}};
      pend_r      <= {(3*DIGITS){1'b0}};
      pend_flag_r <= 1'b0;
    end else begin
      shadow_r    <= shadow_nxt_s;
      pend_r      <= pend_nxt_s;
      pend_flag_r <= pend_flag_nxt_s;
    end
  end

  // Output decode from the upcoming state so the flops match the state.
  always_comb begin
    dec_nxt_s      = 3'd0;
    digit_en_nxt_s = {DIGITS{1'b0}};
    case (state_nxt_s)
      IDLE: begin
        dec_nxt_s      = 3'd0;
        digit_en_nxt_s = {DIGITS{1'b0}};
      end
      BLANK: begin
        dec_nxt_s      = digit_code(shadow_nxt_s, idx_nxt_s);
        digit_en_nxt_s = {DIGITS{1'b0}};
      end
      SHOW: begin
        dec_nxt_s      = digit_code(shadow_nxt_s, idx_nxt_s);
        digit_en_nxt_s = digit_sel(idx_nxt_s);
      end
      default: begin
        dec_nxt_s      = 3'd0;
        digit_en_nxt_s = {DIGITS{1'b0}};
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_in     <= 3'd0;
      digit_en   <= {DIGITS{1'b0}};
      frame_done <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      dec_in     <= dec_nxt_s;
      digit_en   <= digit_en_nxt_s;
      frame_done <= frame_end_s;
      load_ack   <= commit_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: directed scenarios followed by random traffic,
// all checked against a position-in-frame reference model.
module tb_seg_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int SHOW_CYC  = 8;
  localparam int BLANK_CYC = 2;
  localparam int SLOT      = BLANK_CYC + SHOW_CYC;
  localparam int PERIOD    = DIGITS * SLOT;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic                load = 1'b0;
  logic [3*DIGITS-1:0] data_in = '0;
  logic [2:0]          dec_in;
  logic [DIGITS-1:0]   digit_en;
  logic                frame_done;
  logic                load_ack;

  seg_scan_ctrl #(.DIGITS(DIGITS), .SHOW_CYC(SHOW_CYC), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data_in(data_in),
    .dec_in(dec_in), .digit_en(digit_en), .frame_done(frame_done), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: scan position counted from the start edge.
  bit m_run;
  int m_pos;
  bit m_flag;
  int shadow_d[DIGITS];
  int pend_d[DIGITS];
  int e_den, e_dec, e_fd, e_ack;
  int cyc = 0;
  int last_fd = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pos = 0; m_flag = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin shadow_d[i] = 0; pend_d[i] = 0; end
    e_den = 0; e_dec = 0; e_fd = 0; e_ack = 0;
    last_fd = -1;
  endtask

  task automatic model_edge(input bit s_en, input bit s_load, input logic [3*DIGITS-1:0] s_data);
    bit was_idle, fe, commit;
    int p, d, r;
    was_idle = !m_run;
    if (!s_en) begin m_run = 1'b0; m_pos = 0; end
    else if (!m_run) begin m_run = 1'b1; m_pos = 0; end
    else m_pos++;
    fe = s_en && !was_idle && (m_pos % PERIOD == 0);
    commit = (fe && (m_flag || s_load)) || (was_idle && m_flag);
    if (commit) begin
      for (int i = 0; i < DIGITS; i++) shadow_d[i] = s_load ? int'(s_data[3*i +: 3]) : pend_d[i];
      m_flag = 1'b0;
    end else if (s_load) begin
      for (int i = 0; i < DIGITS; i++) pend_d[i] = int'(s_data[3*i +: 3]);
      m_flag = 1'b1;
    end
    if (m_run) begin
      p = m_pos % PERIOD; d = p / SLOT; r = p % SLOT;
      e_den = (r >= BLANK_CYC) ? (1 << d) : 0;
      e_dec = shadow_d[d];
    end else begin
      e_den = 0; e_dec = 0;
    end
    e_fd = int'(fe); e_ack = int'(commit);
  endtask

  task automatic compare_outputs();
    chk("digit_en", 32'(digit_en), 32'(e_den));
    chk("dec_in", 32'(dec_in), 32'(e_dec));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("load_ack", 32'(load_ack), 32'(e_ack));
    chk("onehot", 32'($countones(digit_en) <= 1), 32'd1);
  endtask

  // One clock: advance the model with the inputs the DUT samples, then check.
  task automatic tick();
    bit s_en;
    s_en = en && rst_n;
    if (rst_n) model_edge(en, load, data_in);
    @(posedge clk);
    #1;
    cyc++;
    compare_outputs();
    if (!s_en) last_fd = -1;
    else if (frame_done === 1'b1) begin
      if (last_fd >= 0) chk("frame_period", 32'(cyc - last_fd), 32'(PERIOD));
      last_fd = cyc;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until_den(input int v, input int maxc);
    int n;
    n = 0;
    while (e_den != v && n < maxc) begin tick(); n++; end
    if (e_den != v) chk("wait_den_timeout", 32'(e_den), 32'(v));
  endtask

  task automatic pulse_load(input logic [3*DIGITS-1:0] v);
    load = 1'b1; data_in = v;
    tick();
    load = 1'b0;
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic async_reset(input int hold);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_den", 32'(digit_en), 32'd0);
    chk("rst_dec", 32'(dec_in), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_ack", 32'(load_ack), 32'd0);
    en = 1'b0; load = 1'b0;
    ticks(hold);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    ticks(2);
    #3 rst_n = 1'b1;
    tick();

    // Load while idle: acknowledged one cycle after the load.
    pulse_load(12'o3210);
    chk("idle_ack_early", 32'(load_ack), 32'd0);
    tick();
    chk("idle_ack", 32'(load_ack), 32'd1);
    en = 1'b1;
    tick();
    chk("start_blank", 32'(digit_en), 32'd0);
    ticks(BLANK_CYC);
    chk("first_show", 32'(digit_en), 32'd1);
    ticks(2 * PERIOD);

    // Mid-frame load during digit 1.
    run_until_den(2, 2 * PERIOD);
    pulse_load(12'o7654);
    ticks(2 * PERIOD);

    // Two loads in one frame: the second wins.
    run_until_den(1, 2 * PERIOD);
    pulse_load(12'o1111);
    run_until_den(4, PERIOD);
    pulse_load(12'o2222);
    ticks(2 * PERIOD);

    // Load sampled on the frame-wrap edge.
    begin
      int n = 0;
      while (!(m_run && m_pos % PERIOD == PERIOD - 1) && n < 2 * PERIOD) begin tick(); n++; end
    end
    pulse_load(12'o5555);
    chk("sync_fd", 32'(frame_done), 32'd1);
    chk("sync_ack", 32'(load_ack), 32'd1);
    ticks(PERIOD + 5);

    // Abort during digit 2 then restart.
    run_until_den(4, 2 * PERIOD);
    ticks(3);
    en = 1'b0;
    tick();
    chk("abort_den", 32'(digit_en), 32'd0);
    chk("abort_fd", 32'(frame_done), 32'd0);
    ticks(3);
    en = 1'b1;
    ticks(PERIOD + 5);

    // Reset during digit 3 with a pending load.
    run_until_den(8, 2 * PERIOD);
    pulse_load(12'o1357);
    ticks(2);
    async_reset(2);
    en = 1'b1;
    ticks(2 * PERIOD);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(99) < 97);
      load = ($urandom_range(99) < 6);
      data_in = 12'($urandom);
      tick();
      if ($urandom_range(999) == 0) begin
        async_reset(1);
      end
    end
    load = 1'b0;
    ticks(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, 4, number of multiplexed digits sharing one seven_seg decoder (2..8).
REQ-002 Parameter SHOW_CYC, 8, clock cycles each digit is driven per scan slot (>=1).
REQ-003 Parameter BLANK_CYC, 2, clock cycles with all digits off before each slot (>=1).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  scan enable, level-sensitive.
REQ-007 load  input  1  single-cycle request to take new display data.
REQ-008 data_in  input  3*DIGITS  digit codes, digit i in bits [3i+2:3i].
REQ-009 dec_in  output  3  code driven to the shared seven_seg decoder input.
REQ-010 digit_en  output  DIGITS  one-hot digit select, active-high, all-zero when blanked.
REQ-011 frame_done  output  1  one-cycle pulse at end of the last digit's slot.
REQ-012 load_ack  output  1  one-cycle pulse when pending data is committed to the display buffer.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 FSM states SHALL be IDLE, BLANK, SHOW; digit index idx in 0..DIGITS-1; cycle counter cnt.
REQ-015 IDLE: digit_en=0, dec_in=0; en sampled high at edge t -> BLANK with idx=0, cnt=0.
REQ-016 BLANK: digit_en=0, dec_in=shadow digit idx; after BLANK_CYC cycles -> SHOW, cnt=0.
REQ-017 SHOW: digit_en has only bit idx set, dec_in=shadow digit idx; after SHOW_CYC cycles -> BLANK.
REQ-018 SHOW exit with idx<DIGITS-1 SHALL increment idx; with idx=DIGITS-1 SHALL wrap idx to 0 and pulse frame_done for exactly one cycle.
REQ-019 Latency: en high at edge t gives digit_en=0 for cycles t+1..t+BLANK_CYC, digit_en[0]=1 for cycles t+BLANK_CYC+1..t+BLANK_CYC+SHOW_CYC.
REQ-020 Frame period SHALL be exactly DIGITS*(BLANK_CYC+SHOW_CYC) cycles with no idle gaps while en stays high.
REQ-021 load high SHALL capture data_in into a pending buffer and set a pending flag; a later load before commit SHALL overwrite the pending data.
REQ-022 Commit (shadow<=pending, clear flag, pulse load_ack) SHALL occur only at a frame boundary (the cycle frame_done is asserted) or on the first cycle in IDLE with pending set.
REQ-023 load asserted in the same cycle as the frame boundary SHALL be included in that commit (data_in goes directly to shadow).
REQ-024 A displayed digit SHALL never change code mid-frame; no tearing across a frame.
REQ-025 en low in any state SHALL move to IDLE on the next edge: digit_en=0, dec_in=0, idx=0; no frame_done pulse.
REQ-026 en toggling high after abort SHALL restart at digit 0 with a full BLANK period.
REQ-027 load_ack and frame_done SHALL never be high for more than one consecutive cycle.
REQ-028 At most one digit_en bit SHALL be high in any cycle.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, idx=0, cnt=0, shadow=0, pending=0, pending flag=0, dec_in=0, digit_en=0, frame_done=0, load_ack=0.
REQ-030 Reset release SHALL take effect synchronously; first state change occurs no earlier than the first rising edge with rst_n high.
REQ-031 Reset asserted mid-frame SHALL discard pending data without pulsing load_ack.

Verification (DIGITS=4, SHOW_CYC=8, BLANK_CYC=2)
REQ-032 Reset, load data_in=12'o3210 while IDLE, en=1 -> load_ack one cycle after load; digit_en 0001,0010,0100,1000 each 8 cycles with dec_in 0,1,2,3, 2 blank cycles before each; frame_done every 40 cycles.
REQ-033 Mid-frame load 12'o7654 during digit 1 -> current frame continues 0,1,2,3; load_ack coincides with frame_done; next frame shows 4,5,6,7.
REQ-034 Two loads (12'o1111 then 12'o2222) within one frame -> single load_ack at boundary; next frame shows all 2.
REQ-035 load asserted exactly on frame_done cycle with 12'o5555 -> committed that cycle; next frame shows all 5.
REQ-036 en dropped during digit 2 SHOW -> digit_en=0 next cycle, no frame_done; en re-raised -> 2 blank cycles then digit 0.
REQ-037 rst_n pulsed low during digit 3 with a pending load -> outputs zero immediately, no load_ack; after release and en, all digits show 0.
